// File: rtl/wb_pkg.sv
// Shared writeback definitions: register address width, default data width
// and the buffered writeback entry.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  is_load;
  } wb_entry_t;

endpackage

// File: rtl/wb_if.sv
// Writeback bus: ALU and load-return requests, load issue, hazard query,
// register-file write port and drain status.
interface wb_if #(
  parameter int XLEN = wb_pkg::XLEN
);

  logic                          alu_valid;
  logic [wb_pkg::REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]               alu_data;
  logic                          alu_ready;

  logic                          ld_valid;
  logic [wb_pkg::REG_ADDR_W-1:0] ld_rd;
  logic [XLEN-1:0]               ld_data;
  logic                          ld_ready;

  logic                          issue_ld;
  logic [wb_pkg::REG_ADDR_W-1:0] issue_ld_rd;

  logic [wb_pkg::REG_ADDR_W-1:0] chk_rs1;
  logic [wb_pkg::REG_ADDR_W-1:0] chk_rs2;
  logic                          stall;

  logic                          rf_we;
  logic [wb_pkg::REG_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]               rf_wdata;

  logic                          drained;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  issue_ld, issue_ld_rd,
    input  chk_rs1, chk_rs2,
    output alu_ready, ld_ready, stall,
    output rf_we, rf_rd, rf_wdata, drained
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output issue_ld, issue_ld_rd,
    output chk_rs1, chk_rs2,
    input  alu_ready, ld_ready, stall,
    input  rf_we, rf_rd, rf_wdata, drained
  );

endinterface

// File: rtl/wb_fifo.sv
// Write buffer: two ordered push ports (a ahead of b), one pop, and every
// slot exposed with its valid bit for hazard lookup.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_a,
  input  wb_entry_t               entry_a,
  input  logic                    push_b,
  input  wb_entry_t               entry_b,
  input  logic                    pop,
  output wb_entry_t               head,
  output logic [$clog2(DEPTH):0]  count,
  output wb_entry_t [DEPTH-1:0]   slots,
  output logic [DEPTH-1:0]        slot_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr_b;
  logic                  do_pop;

  assign do_pop   = pop && (count != '0);
  assign wr_ptr_b = push_a ? wr_ptr + PW'(1) : wr_ptr;

  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr]   <= entry_a;
    if (push_b) mem[wr_ptr_b] <= entry_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count  <= count + CW'(push_a) + CW'(push_b) - CW'(do_pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign slots = mem;

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    slot_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_valid[i] = {1'b0, PW'(i) - rd_ptr} < count;
    end
  end

endmodule

// File: rtl/wb_controller.sv
// Writeback controller: buffers ALU/load results, drains one register write
// per cycle, and tracks outstanding loads for decode hazard detection.
module wb_controller #(
  parameter int DEPTH = 4,
  parameter int XLEN  = wb_pkg::XLEN
) (
  input  logic clk,
  input  logic reset,
  wb_if.slave  bus
);

  import wb_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = wb_pkg::XLEN;

  logic [CW-1:0]         count;
  wb_entry_t             head;
  wb_entry_t             entry_ld;
  wb_entry_t             entry_alu;
  wb_entry_t [DEPTH-1:0] slots;
  logic [DEPTH-1:0]      slot_valid;
  logic                  ld_req;
  logic                  ld_take;
  logic                  alu_take;
  logic                  pop;
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_next;
  logic [NUM_REGS-1:0]   set_mask;
  logic [NUM_REGS-1:0]   clr_mask;
  logic                  hit1;
  logic                  hit2;

  // An ALU request only gets a slot if a storable load is not also claiming one.
  assign ld_req        = bus.ld_valid && (bus.ld_rd != '0);
  assign bus.ld_ready  = count < CW'(DEPTH);
  assign bus.alu_ready = count < (CW'(DEPTH) - CW'(ld_req));
  assign ld_take       = ld_req && bus.ld_ready;
  assign alu_take      = bus.alu_valid && bus.alu_ready && (bus.alu_rd != '0);
  assign pop           = count != '0;

  assign entry_ld  = '{rd: bus.ld_rd,  data: DW'(bus.ld_data),  is_load: 1'b1};
  assign entry_alu = '{rd: bus.alu_rd, data: DW'(bus.alu_data), is_load: 1'b0};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_a     (ld_take),
    .entry_a    (entry_ld),
    .push_b     (alu_take),
    .entry_b    (entry_alu),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .slots      (slots),
    .slot_valid (slot_valid)
  );

  always_comb begin
    bus.rf_we    = pop;
    bus.rf_rd    = '0;
    bus.rf_wdata = '0;
    if (pop) begin
      bus.rf_rd    = head.rd;
      bus.rf_wdata = XLEN'(head.data);
    end
  end

  // Set is applied after clear so a re-issue on the popping cycle survives.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.issue_ld && (bus.issue_ld_rd != '0)) set_mask[bus.issue_ld_rd] = 1'b1;
    if (pop && head.is_load) clr_mask[head.rd] = 1'b1;
    pending_next    = (pending & ~clr_mask) | set_mask;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_next;
  end

  always_comb begin
    hit1 = pending[bus.chk_rs1];
    hit2 = pending[bus.chk_rs2];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) begin
        hit1 = hit1 || (slots[i].rd == bus.chk_rs1);
        hit2 = hit2 || (slots[i].rd == bus.chk_rs2);
      end
    end
    bus.stall = ((bus.chk_rs1 != '0) && hit1)
             || ((bus.chk_rs2 != '0) && hit2)
             || (bus.issue_ld && pending[bus.issue_ld_rd]);
  end

  assign bus.drained = (count == '0) && (pending == '0);

endmodule

// File: tb/tb_wb_controller.sv
// Directed bench for wb_controller (DEPTH=4, XLEN=32) with hand-computed
// expectations; inputs change and outputs are sampled just after negedge.
module tb_wb_controller;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  wb_if #(.XLEN(32)) bus ();

  wb_controller #(
    .DEPTH (4),
    .XLEN  (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.ld_valid = v;
    bus.ld_rd    = rd;
    bus.ld_data  = d;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd);
    bus.issue_ld    = v;
    bus.issue_ld_rd = rd;
  endtask

  task automatic idle();
    alu(1'b0, 5'd0, 32'd0);
    ld(1'b0, 5'd0, 32'd0);
    issue(1'b0, 5'd0);
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    check({tag, ".we"},    32'(bus.rf_we), 32'(we));
    check({tag, ".rd"},    32'(bus.rf_rd), 32'(rd));
    check({tag, ".wdata"}, bus.rf_wdata,   d);
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    check(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    reset       = 1'b1;
    bus.chk_rs1 = 5'd5;
    bus.chk_rs2 = 5'd0;
    idle();
    @(negedge clk);
    #1;
    chk_rf("rst", 1'b0, 5'd0, 32'd0);
    chk_bit("rst.stall",     bus.stall,     1'b0);
    chk_bit("rst.drained",   bus.drained,   1'b1);
    chk_bit("rst.alu_ready", bus.alu_ready, 1'b1);
    chk_bit("rst.ld_ready",  bus.ld_ready,  1'b1);
    reset = 1'b0;

    // Single ALU write from empty
    alu(1'b1, 5'd5, 32'h1234);
    #1;
    chk_bit("t1.alu_ready", bus.alu_ready, 1'b1);
    chk_bit("t1.pre_we",    bus.rf_we,     1'b0);
    tick();
    idle();
    #1;
    chk_rf("t1.head", 1'b1, 5'd5, 32'h1234);
    chk_bit("t1.stall_buf", bus.stall,   1'b1);
    chk_bit("t1.drained0",  bus.drained, 1'b0);
    tick();
    chk_rf("t1.after", 1'b0, 5'd0, 32'd0);
    chk_bit("t1.drained1", bus.drained, 1'b1);
    chk_bit("t1.stall0",   bus.stall,   1'b0);
    bus.chk_rs1 = 5'd0;

    // Simultaneous ALU and load: load drains first
    alu(1'b1, 5'd3, 32'h33);
    ld(1'b1, 5'd4, 32'h44);
    #1;
    chk_bit("t2.alu_ready", bus.alu_ready, 1'b1);
    chk_bit("t2.ld_ready",  bus.ld_ready,  1'b1);
    tick();
    idle();
    #1;
    chk_rf("t2.first", 1'b1, 5'd4, 32'h44);
    tick();
    chk_rf("t2.second", 1'b1, 5'd3, 32'h33);
    tick();
    chk_rf("t2.empty", 1'b0, 5'd0, 32'd0);
    chk_bit("t2.drained", bus.drained, 1'b1);

    // Back-pressure: the head pops every cycle, so occupancy peaks at 3
    ld(1'b1, 5'd10, 32'hA0);
    alu(1'b1, 5'd11, 32'hB0);
    tick();
    ld(1'b1, 5'd12, 32'hA1);
    alu(1'b1, 5'd13, 32'hB1);
    #1;
    chk_rf("t3.h10", 1'b1, 5'd10, 32'hA0);
    chk_bit("t3.c2.alu_ready", bus.alu_ready, 1'b1);
    tick();
    ld(1'b1, 5'd14, 32'hA2);
    alu(1'b1, 5'd15, 32'hB2);
    #1;
    chk_rf("t3.h11", 1'b1, 5'd11, 32'hB0);
    chk_bit("t3.c3.ld_ready",  bus.ld_ready,  1'b1);
    chk_bit("t3.c3.alu_ready", bus.alu_ready, 1'b0);
    bus.ld_rd = 5'd0;
    #1;
    chk_bit("t3.ld_rd0.alu_ready", bus.alu_ready, 1'b1);
    bus.ld_rd = 5'd14;
    #1;
    tick();
    bus.ld_valid = 1'b0;
    #1;
    chk_rf("t3.h12", 1'b1, 5'd12, 32'hA1);
    chk_bit("t3.held.alu_ready", bus.alu_ready, 1'b1);
    tick();
    idle();
    #1;
    chk_rf("t3.h13", 1'b1, 5'd13, 32'hB1);
    tick();
    chk_rf("t3.h14", 1'b1, 5'd14, 32'hA2);
    tick();
    chk_rf("t3.h15", 1'b1, 5'd15, 32'hB2);
    tick();
    chk_rf("t3.empty", 1'b0, 5'd0, 32'd0);
    chk_bit("t3.drained", bus.drained, 1'b1);

    // Load scoreboard on x7, ALU write to x0 ignored
    issue(1'b1, 5'd7);
    bus.chk_rs1 = 5'd7;
    #1;
    chk_bit("t4.pre_stall", bus.stall, 1'b0);
    tick();
    issue(1'b0, 5'd0);
    #1;
    chk_bit("t4.stall",   bus.stall,   1'b1);
    chk_bit("t4.drained", bus.drained, 1'b0);
    alu(1'b1, 5'd0, 32'hDEAD);
    #1;
    chk_bit("t4.x0.alu_ready", bus.alu_ready, 1'b1);
    tick();
    idle();
    #1;
    chk_bit("t4.x0.we",    bus.rf_we, 1'b0);
    chk_bit("t4.x0.stall", bus.stall, 1'b1);
    bus.chk_rs1 = 5'd0;
    issue(1'b1, 5'd7);
    #1;
    chk_bit("t4.reissue.stall", bus.stall, 1'b1);
    issue(1'b0, 5'd0);
    #1;
    chk_bit("t4.noquery.stall", bus.stall, 1'b0);
    bus.chk_rs2 = 5'd7;
    #1;
    chk_bit("t4.rs2.stall", bus.stall, 1'b1);
    ld(1'b1, 5'd7, 32'h77);
    tick();
    idle();
    #1;
    chk_rf("t4.ldwr", 1'b1, 5'd7, 32'h77);
    chk_bit("t4.ldwr.stall", bus.stall, 1'b1);
    tick();
    chk_bit("t4.cleared.stall", bus.stall,   1'b0);
    chk_bit("t4.drained",       bus.drained, 1'b1);
    chk_bit("t4.cleared.we",    bus.rf_we,   1'b0);
    bus.chk_rs2 = 5'd0;

    // Re-issue of x6 on the cycle its load pops: pending stays set
    issue(1'b1, 5'd6);
    tick();
    issue(1'b0, 5'd0);
    ld(1'b1, 5'd6, 32'h66);
    tick();
    ld(1'b0, 5'd0, 32'd0);
    #1;
    chk_rf("t5.head", 1'b1, 5'd6, 32'h66);
    issue(1'b1, 5'd6);
    #1;
    chk_bit("t5.reissue.stall", bus.stall, 1'b1);
    tick();
    issue(1'b0, 5'd0);
    bus.chk_rs1 = 5'd6;
    #1;
    chk_bit("t5.kept.stall",   bus.stall,   1'b1);
    chk_bit("t5.kept.drained", bus.drained, 1'b0);
    chk_bit("t5.kept.we",      bus.rf_we,   1'b0);
    ld(1'b1, 5'd6, 32'h67);
    tick();
    ld(1'b0, 5'd0, 32'd0);
    tick();
    chk_bit("t5.final.stall",   bus.stall,   1'b0);
    chk_bit("t5.final.drained", bus.drained, 1'b1);

    // Asynchronous reset mid-burst: count=3, pending[9]=1
    bus.chk_rs1 = 5'd9;
    ld(1'b1, 5'd1, 32'h11);
    alu(1'b1, 5'd2, 32'h22);
    issue(1'b1, 5'd9);
    tick();
    issue(1'b0, 5'd0);
    ld(1'b1, 5'd3, 32'h31);
    alu(1'b1, 5'd4, 32'h41);
    tick();
    idle();
    #1;
    chk_rf("t6.head", 1'b1, 5'd2, 32'h22);
    chk_bit("t6.pre.drained", bus.drained, 1'b0);
    chk_bit("t6.pre.stall",   bus.stall,   1'b1);
    reset = 1'b1;
    #1;
    chk_rf("t6.rst", 1'b0, 5'd0, 32'd0);
    chk_bit("t6.rst.drained",   bus.drained,   1'b1);
    chk_bit("t6.rst.stall",     bus.stall,     1'b0);
    chk_bit("t6.rst.alu_ready", bus.alu_ready, 1'b1);
    chk_bit("t6.rst.ld_ready",  bus.ld_ready,  1'b1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_bit("t6.post.we",      bus.rf_we,   1'b0);
      chk_bit("t6.post.drained", bus.drained, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
